branch_predictor: RTL

- Parametrised dynamic branch predictor for the 5-stage RV32 pipeline. Replaces the fixed "predict every bne taken" rule in decode.
- Direct-mapped table of ENTRIES tagged entries. Each entry holds a valid bit, a tag, a CTR_W-bit saturating counter and a branch target.
- IF looks up the fetch pc combinationally in the same cycle. EX writes back the resolved outcome one clock edge later.

---
 rtl/bpred_pkg.sv | 52 +++++
 rtl/bpred_sat_ctr.sv | 34 +++
 rtl/branch_predictor.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bpred_pkg.sv
// -----------------------------------------------------------------------------
// bpred_pkg
// Shared definitions for the dynamic branch predictor:
//   - bpred_state_t  : table state (ST_INIT while sweeping, ST_RUN afterwards)
//   - bpred_idx/tag  : index and tag extraction from a pc, widths as arguments
//                      so the same helpers serve any ENTRIES / TAG_W choice
//   - counter helpers and the default-width constants CTR_MAX, CTR_WEAK_T,
//     CTR_WEAK_NT
// No ports (package).
// -----------------------------------------------------------------------------
package bpred_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bpred_state_t;

   // Default geometry; the top module parameters default to these values.
   localparam int BPRED_XLEN  = 32;
   localparam int BPRED_IDX_W = 6;
   localparam int BPRED_TAG_W = 8;
   localparam int BPRED_CTR_W = 2;

   // pc helpers work on a 64-bit container so any XLEN up to 64 fits.
   function automatic logic [63:0] bpred_idx(input logic [63:0] pc, input int idx_w);
      return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
   endfunction

   function automatic logic [63:0] bpred_tag(input logic [63:0] pc, input int idx_w,
                                             input int tag_w);
      return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
   endfunction

   function automatic int bpred_ctr_max(input int w);
      return (1 << w) - 1;
   endfunction

   // Weakly taken: MSB set, all other bits clear.
   function automatic int bpred_ctr_weak_t(input int w);
      return 1 << (w - 1);
   endfunction

   // Weakly not-taken: one below weakly taken.
   function automatic int bpred_ctr_weak_nt(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   localparam int CTR_MAX     = bpred_ctr_max(BPRED_CTR_W);
   localparam int CTR_WEAK_T  = bpred_ctr_weak_t(BPRED_CTR_W);
   localparam int CTR_WEAK_NT = bpred_ctr_weak_nt(BPRED_CTR_W);

endpackage

// File: rtl/bpred_sat_ctr.sv
// -----------------------------------------------------------------------------
// bpred_sat_ctr
// Combinational saturating up/down counter step.
// Ports:
//   ctr      in  CTR_W  current counter value
//   taken    in  1      1 = count up, 0 = count down
//   ctr_next out CTR_W  next value, clamped to [0, 2^CTR_W-1]
// -----------------------------------------------------------------------------
module bpred_sat_ctr
   import bpred_pkg::*;
#(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr,
   input  logic             taken,
   output logic [CTR_W-1:0] ctr_next
);

   localparam logic [CTR_W-1:0] MAX_VAL = CTR_W'(bpred_ctr_max(CTR_W));

   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != MAX_VAL) begin
            ctr_next = ctr + CTR_W'(1);
         end
      end else begin
         if (ctr != '0) begin
            ctr_next = ctr - CTR_W'(1);
         end
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped, tagged dynamic branch predictor. Fetch looks up
// combinationally; execute writes the resolved outcome back at the clock edge.
// After reset the table is swept one entry per cycle (w_ready=0 meanwhile).
// Optional statistics counters are built when BPRED_STATS_EN is defined.
// Ports:
//   w_clk            in   clock, rising edge
//   w_rst_n          in   synchronous active-low reset
//   w_ce             in   clock enable for table updates (sweep ignores it)
//   w_ready          out  table initialised
//   w_lk_pc          in   fetch pc
//   w_lk_hit         out  valid entry with matching tag
//   w_lk_taken       out  predict taken
//   w_lk_target      out  predicted target (0 when not taken)
//   w_upd_valid      in   resolved conditional branch present
//   w_upd_pc         in   pc of resolved branch
//   w_upd_taken      in   actual outcome
//   w_upd_target     in   actual taken target
//   w_upd_pred_taken in   prediction carried with the branch
//   w_mispredict     out  w_upd_valid & (pred != actual), combinational
//   w_stat_upd       out  accepted updates    (BPRED_STATS_EN only)
//   w_stat_miss      out  accepted mispredicts (BPRED_STATS_EN only)
// -----------------------------------------------------------------------------
module branch_predictor
   import bpred_pkg::*;
#(
   parameter int XLEN    = BPRED_XLEN,
   parameter int ENTRIES = 64,
   parameter int TAG_W   = BPRED_TAG_W,
   parameter int CTR_W   = BPRED_CTR_W
) (
   input  logic            w_clk,
   input  logic            w_rst_n,
   input  logic            w_ce,
   output logic            w_ready,
   input  logic [XLEN-1:0] w_lk_pc,
   output logic            w_lk_hit,
   output logic            w_lk_taken,
   output logic [XLEN-1:0] w_lk_target,
   input  logic            w_upd_valid,
   input  logic [XLEN-1:0] w_upd_pc,
   input  logic            w_upd_taken,
   input  logic [XLEN-1:0] w_upd_target,
   input  logic            w_upd_pred_taken,
   output logic            w_mispredict
`ifdef BPRED_STATS_EN
   ,
   output logic [31:0]     w_stat_upd,
   output logic [31:0]     w_stat_miss
`endif
);

   localparam int               IDX_W     = $clog2(ENTRIES);
   localparam logic [CTR_W-1:0] CTR_CLEAR = CTR_W'(bpred_ctr_weak_nt(CTR_W));
   localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(bpred_ctr_weak_t(CTR_W));
   localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(ENTRIES - 1);

   bpred_state_t     state_reg, state_next;
   logic [IDX_W-1:0] ptr_reg;

   logic             valid_reg  [ENTRIES];
   logic [TAG_W-1:0] tag_reg    [ENTRIES];
   logic [CTR_W-1:0] ctr_reg    [ENTRIES];
   logic [XLEN-1:0]  target_reg [ENTRIES];

   logic [IDX_W-1:0] lk_idx, upd_idx;
   logic [TAG_W-1:0] lk_tag, upd_tag;
   logic             upd_hit, upd_en;
   logic [CTR_W-1:0] ctr_upd;

   assign lk_idx  = IDX_W'(bpred_idx(64'(w_lk_pc), IDX_W));
   assign lk_tag  = TAG_W'(bpred_tag(64'(w_lk_pc), IDX_W, TAG_W));
   assign upd_idx = IDX_W'(bpred_idx(64'(w_upd_pc), IDX_W));
   assign upd_tag = TAG_W'(bpred_tag(64'(w_upd_pc), IDX_W, TAG_W));

   assign w_ready      = (state_reg == ST_RUN);
   assign w_mispredict = w_upd_valid & (w_upd_pred_taken != w_upd_taken);
   assign upd_en       = w_ready & w_ce & w_upd_valid;
   assign upd_hit      = valid_reg[upd_idx] & (tag_reg[upd_idx] == upd_tag);

   // Lookup reads the registered table, so a same-cycle update is not bypassed.
   always_comb begin
      w_lk_hit    = w_ready & valid_reg[lk_idx] & (tag_reg[lk_idx] == lk_tag);
      w_lk_taken  = w_lk_hit & ctr_reg[lk_idx][CTR_W-1];
      w_lk_target = w_lk_taken ? target_reg[lk_idx] : '0;
   end

   bpred_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
      .ctr      (ctr_reg[upd_idx]),
      .taken    (w_upd_taken),
      .ctr_next (ctr_upd)
   );

   // State machine: next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_INIT: if (ptr_reg == PTR_LAST) state_next = ST_RUN;
         ST_RUN:  state_next = ST_RUN;
         default: state_next = ST_INIT;
      endcase
   end

   always_ff @(posedge w_clk) begin
      if (!w_rst_n) begin
         state_reg <= ST_INIT;
         ptr_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_INIT) begin
            ptr_reg <= ptr_reg + IDX_W'(1);
         end
      end
   end

   // Table storage has no reset of its own; the sweep clears it, and lookups
   // are masked by w_ready until the sweep completes.
   always_ff @(posedge w_clk) begin
      if (w_rst_n) begin
         if (state_reg == ST_INIT) begin
            valid_reg[ptr_reg]  <= 1'b0;
            ctr_reg[ptr_reg]    <= CTR_CLEAR;
            target_reg[ptr_reg] <= '0;
         end else if (upd_en) begin
            if (upd_hit) begin
               ctr_reg[upd_idx] <= ctr_upd;
               if (w_upd_taken) begin
                  target_reg[upd_idx] <= w_upd_target;
               end
            end else if (w_upd_taken) begin
               // Taken miss: claim the slot, evicting any alias.
               valid_reg[upd_idx]  <= 1'b1;
               tag_reg[upd_idx]    <= upd_tag;
               ctr_reg[upd_idx]    <= CTR_ALLOC;
               target_reg[upd_idx] <= w_upd_target;
            end
         end
      end
   end

`ifdef BPRED_STATS_EN
   logic [31:0] stat_upd_reg, stat_miss_reg;

   always_ff @(posedge w_clk) begin
      if (!w_rst_n) begin
         stat_upd_reg  <= '0;
         stat_miss_reg <= '0;
      end else if (upd_en) begin
         if (stat_upd_reg != '1) begin
            stat_upd_reg <= stat_upd_reg + 32'd1;
         end
         if (w_mispredict && (stat_miss_reg != '1)) begin
            stat_miss_reg <= stat_miss_reg + 32'd1;
         end
      end
   end

   assign w_stat_upd  = stat_upd_reg;
   assign w_stat_miss = stat_miss_reg;
`endif

endmodule
